// File: rtl/blob_pkg.sv
// Shared widths, constants, FSM state type and radius helper for the blob statistics stage.
package blob_pkg;

  localparam int unsigned COUNT_W = 17;
  localparam int unsigned SUM_W   = 25;
  localparam int unsigned COORD_W = 9;

  localparam logic [COORD_W-1:0] NO_BLOB = 9'h1FF;

  typedef enum logic [1:0] {ACCUM, DIVIDE, PUBLISH} state_t;

  // Half the mean of the box width and height, saturated to 8 bits.
  function automatic logic [7:0] calc_radius(input logic [COORD_W-1:0] min_x,
                                             input logic [COORD_W-1:0] max_x,
                                             input logic [COORD_W-1:0] min_y,
                                             input logic [COORD_W-1:0] max_y);
    logic [10:0] span;
    logic [10:0] quarter;
    span    = {2'b00, max_x - min_x} + {2'b00, max_y - min_y} + 11'd2;
    quarter = span >> 2;
    return (quarter > 11'd255) ? 8'hFF : quarter[7:0];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done_out pulses DIVIDEND_W cycles
// after start_in is sampled.
module seq_divider #(
  parameter int unsigned DIVIDEND_W = 25,
  parameter int unsigned DIVISOR_W  = 17,
  parameter int unsigned QUOTIENT_W = 9
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [DIVIDEND_W-1:0] dividend_in,
  input  logic [DIVISOR_W-1:0]  divisor_in,
  output logic [QUOTIENT_W-1:0] quotient_out,
  output logic                  done_out
);

  localparam int unsigned STEP_W = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  div_q;
  logic [STEP_W-1:0]     steps_q;
  logic                  running_q;
  logic                  done_q;

  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W+1:0]  diff;
  logic                  fits;

  always_comb begin
    shifted = {rem_q, quo_q[DIVIDEND_W-1]};
    diff    = {1'b0, shifted} - {2'b00, div_q};
    fits    = ~diff[DIVISOR_W+1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      steps_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_in) begin
        quo_q     <= dividend_in;
        rem_q     <= '0;
        div_q     <= divisor_in;
        steps_q   <= STEP_W'(DIVIDEND_W);
        running_q <= 1'b1;
      end else if (running_q) begin
        quo_q   <= {quo_q[DIVIDEND_W-2:0], fits};
        // A failed trial leaves shifted < divisor, so its top bit is always zero.
        rem_q   <= fits ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
        steps_q <= steps_q - STEP_W'(1);
        if (steps_q == STEP_W'(1)) begin
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign quotient_out = quo_q[QUOTIENT_W-1:0];
  assign done_out     = done_q;

endmodule

// File: rtl/blob_centroid.sv
// Per-frame blob statistics: accumulates matching pixels, then divides out the centroid and
// publishes centre, radius and count with a one-cycle valid strobe.
module blob_centroid
  import blob_pkg::*;
#(
  parameter int unsigned FRAME_W    = 320,
  parameter int unsigned FRAME_H    = 240,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               match_in,
  input  logic               frame_end_in,
  output logic [COORD_W-1:0] x_center_out,
  output logic [COORD_W-1:0] y_center_out,
  output logic [7:0]         radius_out,
  output logic [COUNT_W-1:0] pixel_count_out,
  output logic               found_out,
  output logic               valid_out,
  output logic               busy_out,
  output logic               overrun_out
);

  state_t state_q;

  logic [COUNT_W-1:0] count_q, count_upd;
  logic [SUM_W-1:0]   sum_x_q, sum_x_upd, sum_y_q, sum_y_upd;
  logic [COORD_W-1:0] min_x_q, min_x_upd, max_x_q, max_x_upd;
  logic [COORD_W-1:0] min_y_q, min_y_upd, max_y_q, max_y_upd;

  logic [COUNT_W-1:0] snap_count_q;
  logic [7:0]         snap_radius_q;

  logic               hit;
  logic [COORD_W-1:0] px, py;
  logic               start;
  logic [COUNT_W-1:0] divisor;
  logic [COORD_W-1:0] quo_x, quo_y;
  logic               done_x, done_y;

  always_comb begin
    hit = match_in && (hcount_in < 11'(FRAME_W)) && (vcount_in < 10'(FRAME_H));
    px  = hcount_in[COORD_W-1:0];
    py  = vcount_in[COORD_W-1:0];

    count_upd = count_q;
    sum_x_upd = sum_x_q;
    sum_y_upd = sum_y_q;
    min_x_upd = min_x_q;
    max_x_upd = max_x_q;
    min_y_upd = min_y_q;
    max_y_upd = max_y_q;
    if (hit) begin
      count_upd = count_q + COUNT_W'(1);
      sum_x_upd = sum_x_q + {{(SUM_W-COORD_W){1'b0}}, px};
      sum_y_upd = sum_y_q + {{(SUM_W-COORD_W){1'b0}}, py};
      if (px < min_x_q) min_x_upd = px;
      if (px > max_x_q) max_x_upd = px;
      if (py < min_y_q) min_y_upd = py;
      if (py > max_y_q) max_y_upd = py;
    end

    // Dividers load the totals including this cycle's pixel, at the same edge as the snapshot.
    start   = frame_end_in && (state_q == ACCUM);
    divisor = (count_upd == '0) ? COUNT_W'(1) : count_upd;
  end

  seq_divider #(
    .DIVIDEND_W(SUM_W),
    .DIVISOR_W (COUNT_W),
    .QUOTIENT_W(COORD_W)
  ) u_div_x (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start),
    .dividend_in (sum_x_upd),
    .divisor_in  (divisor),
    .quotient_out(quo_x),
    .done_out    (done_x)
  );

  seq_divider #(
    .DIVIDEND_W(SUM_W),
    .DIVISOR_W (COUNT_W),
    .QUOTIENT_W(COORD_W)
  ) u_div_y (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start),
    .dividend_in (sum_y_upd),
    .divisor_in  (divisor),
    .quotient_out(quo_y),
    .done_out    (done_y)
  );

  // Accumulators run in every state; a frame end always restarts them empty.
  always_ff @(posedge clk_in) begin
    if (rst_in || frame_end_in) begin
      count_q <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
      min_x_q <= '1;
      max_x_q <= '0;
      min_y_q <= '1;
      max_y_q <= '0;
    end else begin
      count_q <= count_upd;
      sum_x_q <= sum_x_upd;
      sum_y_q <= sum_y_upd;
      min_x_q <= min_x_upd;
      max_x_q <= max_x_upd;
      min_y_q <= min_y_upd;
      max_y_q <= max_y_upd;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= ACCUM;
      snap_count_q    <= '0;
      snap_radius_q   <= '0;
      x_center_out    <= NO_BLOB;
      y_center_out    <= NO_BLOB;
      radius_out      <= '0;
      pixel_count_out <= '0;
      found_out       <= 1'b0;
      valid_out       <= 1'b0;
      overrun_out     <= 1'b0;
    end else begin
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
      unique case (state_q)
        ACCUM: begin
          if (frame_end_in) begin
            snap_count_q  <= count_upd;
            snap_radius_q <= calc_radius(min_x_upd, max_x_upd, min_y_upd, max_y_upd);
            state_q       <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (frame_end_in) overrun_out <= 1'b1;
          if (done_x && done_y) begin
            pixel_count_out <= snap_count_q;
            valid_out       <= 1'b1;
            state_q         <= PUBLISH;
            if (snap_count_q >= COUNT_W'(MIN_PIXELS)) begin
              found_out    <= 1'b1;
              x_center_out <= quo_x;
              y_center_out <= quo_y;
              radius_out   <= snap_radius_q;
            end else begin
              found_out    <= 1'b0;
              x_center_out <= NO_BLOB;
              y_center_out <= NO_BLOB;
              radius_out   <= '0;
            end
          end
        end
        PUBLISH: begin
          if (frame_end_in) overrun_out <= 1'b1;
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign busy_out = (state_q == DIVIDE);

endmodule

// File: tb/tb_blob_centroid.sv
// Directed bench for blob_centroid: hand-computed centroids, boundaries, overrun and reset abort.
module tb_blob_centroid;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        match_in;
  logic        frame_end_in;
  logic [8:0]  x_center_out;
  logic [8:0]  y_center_out;
  logic [7:0]  radius_out;
  logic [16:0] pixel_count_out;
  logic        found_out;
  logic        valid_out;
  logic        busy_out;
  logic        overrun_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  blob_centroid dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .match_in       (match_in),
    .frame_end_in   (frame_end_in),
    .x_center_out   (x_center_out),
    .y_center_out   (y_center_out),
    .radius_out     (radius_out),
    .pixel_count_out(pixel_count_out),
    .found_out      (found_out),
    .valid_out      (valid_out),
    .busy_out       (busy_out),
    .overrun_out    (overrun_out)
  );

  // Inputs change on the falling edge and are sampled at the following rising edge.
  task automatic drive(input int h, input int v, input logic m, input logic fe);
    @(negedge clk_in);
    hcount_in    = 11'(h);
    vcount_in    = 10'(v);
    match_in     = m;
    frame_end_in = fe;
  endtask

  task automatic send_square(input int c0, input int l0);
    for (int i = 0; i < 16; i++) drive(c0 + i % 4, l0 + i / 4, 1'b1, 1'b0);
  endtask

  // Call right after frame_end has been driven; edges counts rising edges from E (E = 1).
  task automatic wait_valid(output int edges, output logic busy_first);
    edges      = 0;
    busy_first = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_in);
      match_in     = 1'b0;
      frame_end_in = 1'b0;
      if (k == 1) busy_first = busy_out;
      if (valid_out) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1; hcount_in = '0; vcount_in = '0; match_in = 1'b0; frame_end_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    n_cmp++; if (x_center_out !== 9'h1FF) begin n_bad++; $display("FAIL reset_x: got %h want 1ff", x_center_out); end
    n_cmp++; if (y_center_out !== 9'h1FF) begin n_bad++; $display("FAIL reset_y: got %h want 1ff", y_center_out); end
    n_cmp++; if (radius_out !== 8'd0) begin n_bad++; $display("FAIL reset_radius: got %0d want 0", radius_out); end
    n_cmp++; if (pixel_count_out !== 17'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", pixel_count_out); end
    n_cmp++; if ({found_out, valid_out, busy_out, overrun_out} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {found_out, valid_out, busy_out, overrun_out});
    end
  endtask

  task automatic test_square;
    int e; logic b;
    send_square(100, 50);
    drive(0, 0, 1'b0, 1'b1);
    wait_valid(e, b);
    n_cmp++; if (e !== 27) begin n_bad++; $display("FAIL sq_latency: got %0d want 27", e); end
    n_cmp++; if (b !== 1'b1) begin n_bad++; $display("FAIL sq_busy: got %b want 1", b); end
    n_cmp++; if (x_center_out !== 9'd101) begin n_bad++; $display("FAIL sq_x: got %0d want 101", x_center_out); end
    n_cmp++; if (y_center_out !== 9'd51) begin n_bad++; $display("FAIL sq_y: got %0d want 51", y_center_out); end
    n_cmp++; if (radius_out !== 8'd2) begin n_bad++; $display("FAIL sq_radius: got %0d want 2", radius_out); end
    n_cmp++; if (pixel_count_out !== 17'd16) begin n_bad++; $display("FAIL sq_count: got %0d want 16", pixel_count_out); end
    n_cmp++; if (found_out !== 1'b1) begin n_bad++; $display("FAIL sq_found: got %b want 1", found_out); end
    @(negedge clk_in);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL sq_pulse: got %b want 0", valid_out); end
    n_cmp++; if (x_center_out !== 9'd101) begin n_bad++; $display("FAIL sq_hold: got %0d want 101", x_center_out); end
  endtask

  task automatic test_full_frame;
    int e; logic b;
    for (int v = 0; v < 240; v++)
      for (int h = 0; h < 320; h++) drive(h, v, 1'b1, (h == 319) && (v == 239));
    wait_valid(e, b);
    n_cmp++; if (e !== 27) begin n_bad++; $display("FAIL full_latency: got %0d want 27", e); end
    n_cmp++; if (pixel_count_out !== 17'd76800) begin n_bad++; $display("FAIL full_count: got %0d want 76800", pixel_count_out); end
    n_cmp++; if (x_center_out !== 9'd159) begin n_bad++; $display("FAIL full_x: got %0d want 159", x_center_out); end
    n_cmp++; if (y_center_out !== 9'd119) begin n_bad++; $display("FAIL full_y: got %0d want 119", y_center_out); end
    n_cmp++; if (radius_out !== 8'd140) begin n_bad++; $display("FAIL full_radius: got %0d want 140", radius_out); end
    n_cmp++; if (found_out !== 1'b1) begin n_bad++; $display("FAIL full_found: got %b want 1", found_out); end
  endtask

  task automatic test_sparse;
    int e; logic b;
    drive(30, 40, 1'b1, 1'b0);
    drive(31, 40, 1'b1, 1'b0);
    drive(32, 41, 1'b1, 1'b0);
    drive(33, 42, 1'b1, 1'b0);
    drive(34, 43, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    wait_valid(e, b);
    n_cmp++; if (e !== 27) begin n_bad++; $display("FAIL sparse_latency: got %0d want 27", e); end
    n_cmp++; if (pixel_count_out !== 17'd5) begin n_bad++; $display("FAIL sparse_count: got %0d want 5", pixel_count_out); end
    n_cmp++; if (found_out !== 1'b0) begin n_bad++; $display("FAIL sparse_found: got %b want 0", found_out); end
    n_cmp++; if (x_center_out !== 9'h1FF) begin n_bad++; $display("FAIL sparse_x: got %h want 1ff", x_center_out); end
    n_cmp++; if (y_center_out !== 9'h1FF) begin n_bad++; $display("FAIL sparse_y: got %h want 1ff", y_center_out); end
    n_cmp++; if (radius_out !== 8'd0) begin n_bad++; $display("FAIL sparse_radius: got %0d want 0", radius_out); end
  endtask

  task automatic test_window_edges;
    int e; logic b;
    drive(500, 5, 1'b1, 1'b0);
    drive(5, 300, 1'b1, 1'b0);
    drive(500, 300, 1'b1, 1'b0);
    drive(320, 10, 1'b1, 1'b0);
    drive(10, 240, 1'b1, 1'b0);
    drive(10, 10, 1'b1, 1'b1);
    wait_valid(e, b);
    n_cmp++; if (e !== 27) begin n_bad++; $display("FAIL win_latency: got %0d want 27", e); end
    n_cmp++; if (pixel_count_out !== 17'd1) begin n_bad++; $display("FAIL win_count: got %0d want 1", pixel_count_out); end
    n_cmp++; if (found_out !== 1'b0) begin n_bad++; $display("FAIL win_found: got %b want 0", found_out); end
    n_cmp++; if (x_center_out !== 9'h1FF) begin n_bad++; $display("FAIL win_x: got %h want 1ff", x_center_out); end
  endtask

  task automatic test_overrun;
    int n_valid = 0, k_valid = 0, n_ovr = 0, k_ovr = 0, e;
    logic [8:0] x_cap = '0, y_cap = '0;
    logic [16:0] c_cap = '0;
    logic b;
    send_square(100, 50);
    drive(0, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (valid_out) begin
        n_valid++; k_valid = k; x_cap = x_center_out; y_cap = y_center_out; c_cap = pixel_count_out;
      end
      if (overrun_out) begin n_ovr++; k_ovr = k; end
      frame_end_in = (k == 10);
      if (k >= 2 && k <= 4) begin
        hcount_in = 11'd20; vcount_in = 10'd20; match_in = 1'b1;
      end else if (k >= 12 && k <= 27) begin
        hcount_in = 11'(200 + (k - 12) % 4); vcount_in = 10'(10 + (k - 12) / 4); match_in = 1'b1;
      end else begin
        match_in = 1'b0;
      end
    end
    n_cmp++; if (n_ovr !== 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr); end
    n_cmp++; if (k_ovr !== 11) begin n_bad++; $display("FAIL ovr_when: got %0d want 11", k_ovr); end
    n_cmp++; if (n_valid !== 1) begin n_bad++; $display("FAIL ovr_valids: got %0d want 1", n_valid); end
    n_cmp++; if (k_valid !== 27) begin n_bad++; $display("FAIL ovr_latency: got %0d want 27", k_valid); end
    n_cmp++; if (x_cap !== 9'd101) begin n_bad++; $display("FAIL ovr_x: got %0d want 101", x_cap); end
    n_cmp++; if (y_cap !== 9'd51) begin n_bad++; $display("FAIL ovr_y: got %0d want 51", y_cap); end
    n_cmp++; if (c_cap !== 17'd16) begin n_bad++; $display("FAIL ovr_count: got %0d want 16", c_cap); end
    n_cmp++; if (x_center_out !== 9'd101) begin n_bad++; $display("FAIL ovr_hold: got %0d want 101", x_center_out); end
    drive(0, 0, 1'b0, 1'b1);
    wait_valid(e, b);
    n_cmp++; if (pixel_count_out !== 17'd16) begin n_bad++; $display("FAIL next_count: got %0d want 16", pixel_count_out); end
    n_cmp++; if (x_center_out !== 9'd201) begin n_bad++; $display("FAIL next_x: got %0d want 201", x_center_out); end
    n_cmp++; if (y_center_out !== 9'd11) begin n_bad++; $display("FAIL next_y: got %0d want 11", y_center_out); end
  endtask

  task automatic test_reset_mid_divide;
    int n_valid = 0, e;
    logic b;
    send_square(100, 50);
    drive(0, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      frame_end_in = 1'b0;
      match_in     = 1'b0;
      if (valid_out) n_valid++;
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    n_cmp++; if (x_center_out !== 9'h1FF) begin n_bad++; $display("FAIL rst_x: got %h want 1ff", x_center_out); end
    n_cmp++; if (pixel_count_out !== 17'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", pixel_count_out); end
    n_cmp++; if ({found_out, valid_out, busy_out} !== 3'b000) begin
      n_bad++; $display("FAIL rst_flags: got %b want 000", {found_out, valid_out, busy_out});
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (valid_out) n_valid++;
    end
    n_cmp++; if (n_valid !== 0) begin n_bad++; $display("FAIL rst_novalid: got %0d want 0", n_valid); end
    send_square(100, 50);
    drive(0, 0, 1'b0, 1'b1);
    wait_valid(e, b);
    n_cmp++; if (e !== 27) begin n_bad++; $display("FAIL post_latency: got %0d want 27", e); end
    n_cmp++; if (x_center_out !== 9'd101) begin n_bad++; $display("FAIL post_x: got %0d want 101", x_center_out); end
    n_cmp++; if (pixel_count_out !== 17'd16) begin n_bad++; $display("FAIL post_count: got %0d want 16", pixel_count_out); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_full_frame();
    test_sparse();
    test_window_edges();
    test_overrun();
    test_reset_mid_divide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
